// File: rtl/debug_controller.sv
// Host-side debug sequencer: decodes UART command bytes, steps/runs the pipeline via pipe_en,
// and streams probe or cycle-count replies LSB first. Optional breakpoint: DEBUG_BREAKPOINT_EN.
module debug_controller #(
    parameter int unsigned CYCLE_W   = 32,
    parameter int unsigned RUN_LIMIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               tx_busy,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic [5:0]         probe_sel,
    input  logic [31:0]        probe_data,
    output logic               pipe_en,
    output logic               halted,
`ifdef DEBUG_BREAKPOINT_EN
    input  logic [31:0]        bp_pc,
    input  logic [31:0]        bp_addr,
`endif
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam logic [5:0] SEL_STEP = 6'h3F;
    localparam logic [5:0] SEL_RUN  = 6'h38;
    localparam logic [5:0] SEL_CNT  = 6'h3E;
`ifdef DEBUG_BREAKPOINT_EN
    localparam logic [5:0] SEL_BP   = 6'h3C;
`endif

    typedef enum logic [2:0] {IDLE, STEP, RUN, LATCH, SEND, WAIT_TX} state_t;

    state_t      state, state_d;
    logic        pipe_q, pipe_d;
    logic        halted_d, tx_start_d;
    logic [7:0]  tx_data_d;
    logic [5:0]  probe_sel_d;
    logic [31:0] shadow, shadow_d;
    logic [2:0]  nbytes, nbytes_d;
    logic [31:0] run_cnt, run_cnt_d;
    logic        bp_hit;
    logic        limit_hit;

`ifdef DEBUG_BREAKPOINT_EN
    logic armed, armed_d;
    // Breakpoint gates the enable combinationally so the matching instruction never advances.
    assign bp_hit = armed && (state == RUN) && (bp_pc == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    assign pipe_en   = pipe_q & ~bp_hit;
    assign limit_hit = (RUN_LIMIT != 0) && (run_cnt == 32'(RUN_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pipe_q      <= 1'b0;
            halted      <= 1'b1;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            probe_sel   <= 6'h00;
            shadow      <= 32'h0;
            nbytes      <= 3'd0;
            run_cnt     <= 32'h0;
            cycle_count <= '0;
`ifdef DEBUG_BREAKPOINT_EN
            armed       <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            pipe_q      <= pipe_d;
            halted      <= halted_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            probe_sel   <= probe_sel_d;
            shadow      <= shadow_d;
            nbytes      <= nbytes_d;
            run_cnt     <= run_cnt_d;
            if (pipe_en)
                cycle_count <= cycle_count + CYCLE_W'(1);
`ifdef DEBUG_BREAKPOINT_EN
            armed       <= armed_d;
`endif
        end
    end

    always_comb begin
        state_d     = state;
        pipe_d      = 1'b0;
        halted_d    = 1'b1;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data;
        probe_sel_d = probe_sel;
        shadow_d    = shadow;
        nbytes_d    = nbytes;
        run_cnt_d   = run_cnt;
`ifdef DEBUG_BREAKPOINT_EN
        armed_d     = armed;
`endif
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data[5:0])
                        SEL_STEP: begin
                            state_d = STEP;
                            pipe_d  = 1'b1;
                        end
                        SEL_RUN: begin
                            state_d   = RUN;
                            pipe_d    = 1'b1;
                            halted_d  = 1'b0;
                            run_cnt_d = 32'h0;
                        end
                        SEL_CNT: begin
                            shadow_d = 32'(cycle_count);
                            nbytes_d = 3'd4;
                            state_d  = SEND;
                        end
`ifdef DEBUG_BREAKPOINT_EN
                        SEL_BP: armed_d = 1'b1;
`endif
                        default: begin
                            probe_sel_d = rx_data[5:0];
                            nbytes_d    = 3'(rx_data[7:6]) + 3'd1;
                            state_d     = LATCH;
                        end
                    endcase
                end
            end
            STEP: state_d = IDLE;
            RUN: begin
                // The stop byte is consumed here; the current cycle still counts as executed.
                run_cnt_d = run_cnt + 32'd1;
                if (rx_valid || limit_hit || bp_hit) begin
                    state_d = IDLE;
`ifdef DEBUG_BREAKPOINT_EN
                    armed_d = 1'b0;
`endif
                end else begin
                    pipe_d   = 1'b1;
                    halted_d = 1'b0;
                end
            end
            LATCH: begin
                shadow_d = probe_data;
                state_d  = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = shadow[7:0];
                    state_d    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                shadow_d = shadow >> 8;
                nbytes_d = nbytes - 3'd1;
                state_d  = (nbytes == 3'd1) ? IDLE : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_controller.sv
// Self-checking bench for debug_controller: directed steps plus randomized probe reads
// checked against a byte-stream model of the probe memory and cycle counter.
module tb_debug_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0, rx_valid2 = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy;
    logic        tx_start, tx_start2;
    logic [7:0]  tx_data, tx_data2;
    logic [5:0]  probe_sel, probe_sel2;
    logic [31:0] probe_data;
    logic        pipe_en, pipe_en2, halted, halted2;
    logic [31:0] cycle_count;
    logic [15:0] cycle_count2;

    logic [31:0] probe_mem [64];
    logic [7:0]  txq[$], txq2[$];
    int          pe_cnt = 0, pe_long = 0, pe_cnt2 = 0;
    logic        pe_prev = 1'b0;
    int          busy_cnt = 0;
    int          busy_len = 10;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign probe_data = probe_mem[probe_sel];
    assign tx_busy    = (busy_cnt != 0);

    debug_controller #(.CYCLE_W(32), .RUN_LIMIT(0)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .probe_sel(probe_sel), .probe_data(probe_data), .pipe_en(pipe_en),
        .halted(halted), .cycle_count(cycle_count)
    );

    debug_controller #(.CYCLE_W(16), .RUN_LIMIT(20)) dut2 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid2), .rx_data(rx_data),
        .tx_busy(1'b0), .tx_start(tx_start2), .tx_data(tx_data2),
        .probe_sel(probe_sel2), .probe_data(32'h0), .pipe_en(pipe_en2),
        .halted(halted2), .cycle_count(cycle_count2)
    );

    // UART transmitter: busy for busy_len cycles after each start strobe.
    always @(posedge clk) begin
        if (tx_start)
            busy_cnt <= busy_len;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (tx_start)  txq.push_back(tx_data);
        if (tx_start2) txq2.push_back(tx_data2);
        if (pipe_en) begin
            pe_cnt <= pe_cnt + 1;
            if (pe_prev) pe_long <= pe_long + 1;
        end
        pe_prev <= pipe_en;
        if (pipe_en2) pe_cnt2 <= pe_cnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit second);
        @(negedge clk);
        rx_data = b;
        if (second) rx_valid2 = 1'b1; else rx_valid = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    // Expected reply: the n low bytes of val, least significant first, and nothing more.
    task automatic expect_reply(input string tag, input bit second, input int base,
                                input logic [31:0] val, input int n);
        int budget = 0;
        int sz;
        sz = second ? txq2.size() : txq.size();
        while (sz < base + n && budget < 400) begin
            @(negedge clk);
            budget++;
            sz = second ? txq2.size() : txq.size();
        end
        repeat (30) @(negedge clk);
        sz = second ? txq2.size() : txq.size();
        check({tag, " count"}, 32'(sz - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < sz)
                check($sformatf("%s byte%0d", tag, i),
                      32'(second ? txq2[base + i] : txq[base + i]),
                      (val >> (8 * i)) & 32'hFF);
        end
    endtask

    initial begin
        int base, pe0, cc, sel, size, t;
        for (int i = 0; i < 64; i++) probe_mem[i] = $urandom;
        probe_mem[1] = 32'hDEADBEEF;
        cc = 0;

        repeat (3) @(negedge clk);
        check("rst pipe_en", 32'(pipe_en), 32'd0);
        check("rst halted", 32'(halted), 32'd1);
        check("rst tx_start", 32'(tx_start), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst probe_sel", 32'(probe_sel), 32'd0);
        check("rst cycle_count", cycle_count, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        pe0 = pe_cnt; base = txq.size();
        for (int i = 0; i < 3; i++) begin
            send(8'h3F, 1'b0);
            repeat (3) @(negedge clk);
        end
        cc += 3;
        check("step pulses", 32'(pe_cnt - pe0), 32'd3);
        check("step width", 32'(pe_long), 32'd0);
        check("step cycle_count", cycle_count, 32'(cc));
        check("step no tx", 32'(txq.size() - base), 32'd0);

        base = txq.size();
        send(8'hC1, 1'b0);
        expect_reply("read4", 1'b0, base, 32'hDEADBEEF, 4);
        check("read4 probe_sel", 32'(probe_sel), 32'd1);

        base = txq.size();
        send(8'h01, 1'b0);
        expect_reply("read1", 1'b0, base, 32'hDEADBEEF, 1);

        pe0 = pe_cnt; base = txq.size();
        send(8'h38, 1'b0);
        check("run halted", 32'(halted), 32'd0);
        check("run pipe_en", 32'(pipe_en), 32'd1);
        repeat (48) @(negedge clk);
        send(8'h00, 1'b0);
        cc += 50;
        check("stop halted", 32'(halted), 32'd1);
        check("stop pipe_en", 32'(pipe_en), 32'd0);
        repeat (20) @(negedge clk);
        check("run cycles", 32'(pe_cnt - pe0), 32'd50);
        check("run cycle_count", cycle_count, 32'(cc));
        check("stop not decoded", 32'(probe_sel), 32'd1);
        check("stop no tx", 32'(txq.size() - base), 32'd0);

        base = txq.size();
        send(8'hFE, 1'b0);
        expect_reply("count", 1'b0, base, 32'(cc), 4);

        for (int k = 0; k < 8; k++) begin
            do sel = $urandom_range(0, 63);
            while (sel == 6'h3F || sel == 6'h38 || sel == 6'h3E);
            size     = $urandom_range(0, 3);
            busy_len = $urandom_range(1, 12);
            base     = txq.size();
            send({2'(size), 6'(sel)}, 1'b0);
            expect_reply($sformatf("rand%0d", k), 1'b0, base, probe_mem[sel], size + 1);
            check($sformatf("rand%0d sel", k), 32'(probe_sel), 32'(sel));
        end

        busy_len = 10; pe0 = pe_cnt; base = txq.size();
        send(8'hC5, 1'b0);
        repeat (6) @(negedge clk);
        send(8'h3F, 1'b0);
        expect_reply("ignored", 1'b0, base, probe_mem[5], 4);
        check("ignored no step", 32'(pe_cnt - pe0), 32'd0);
        check("ignored cycle_count", cycle_count, 32'(cc));

        send(8'h38, 1'b1);
        t = 0;
        while (halted2 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("limit halted", 32'(halted2), 32'd1);
        check("limit cycle_count", 32'(cycle_count2), 32'd20);
        check("limit cycles", 32'(pe_cnt2), 32'd20);
        base = txq2.size();
        send(8'hFE, 1'b1);
        expect_reply("limit count", 1'b1, base, 32'h14, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Host-side sequencer for the MIPS debug path; sits between the UART byte interface and the pipeline probe mux.
- Decodes command bytes (bits [7:6] size, bits [5:0] select) and single-steps or free-runs the pipeline through a clock-enable.
- For read commands, latches the selected 32-bit probe value and streams 1-4 bytes back to the UART transmitter.
- Replaces the clock-from-command-code scheme with a proper single-clock enable.

Parameters:
- CYCLE_W, 32, width of the executed-cycle counter (8..32).
- RUN_LIMIT, 0, maximum cycles in RUN before auto-halt; 0 = unlimited.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received command byte.
- rx_data  in  8  command byte.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle strobe: send tx_data.
- tx_data  out  8  byte to transmit.
- probe_sel  out  6  select code driven to the probe mux.
- probe_data  in  32  probe mux result; combinational from probe_sel.
- pipe_en  out  1  pipeline clock enable; the pipeline advances on clk when pipe_en=1.
- halted  out  1  high when the pipeline is not running.
- cycle_count  out  CYCLE_W  number of cycles executed since reset.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, pipe_en=0, halted=1, tx_start=0, tx_data=0, probe_sel=0, cycle_count=0, byte counter=0. Reset in any state aborts the operation; a partly sent reply is dropped.
- States: IDLE, STEP, RUN, LATCH, SEND, WAIT_TX.
- IDLE, on rx_valid with select = 6'b111111: go to STEP.
  - STEP asserts pipe_en for exactly 1 cycle, then returns to IDLE.
  - Size bits are ignored; no reply byte is sent.
- IDLE, on rx_valid with select = 6'b111000: go to RUN; halted=0 the next cycle.
- IDLE, on rx_valid with select = 6'b111110: reply with cycle_count (zero-extended to 32 bits).
- IDLE, on rx_valid with any other select: read probe.
  - Register probe_sel=select and N=size+1 (00 -> 1 byte, 11 -> 4 bytes).
  - Go to LATCH. LATCH captures probe_data into the 32-bit shadow register one cycle after probe_sel settles.
- SEND:
  - Wait while tx_busy=1.
  - When tx_busy=0, drive tx_data = shadow[7:0] and pulse tx_start for 1 cycle, then go to WAIT_TX.
  - Bytes are sent LSB first.
- WAIT_TX:
  - Wait 1 cycle for tx_busy to rise, then return to SEND.
  - Shift shadow right by 8 and decrement N.
  - Go to IDLE after N bytes have been sent.
- RUN:
  - pipe_en=1 every cycle.
  - Leave RUN when any rx_valid arrives (that byte is consumed as "stop", not decoded) or cycle_count reaches the RUN_LIMIT boundary when RUN_LIMIT≠0. The stop byte still counts the current cycle as executed.
  - On leaving: pipe_en=0 on the following cycle, halted=1, go to IDLE.
- cycle_count increments on every cycle with pipe_en=1 and wraps modulo 2^CYCLE_W.
- rx_valid outside IDLE and RUN is ignored and dropped; there is no queue.
- Simultaneous RUN_LIMIT hit and rx_valid: a single halt; the byte is consumed.
- halted=0 only in RUN.
- probe_sel holds its last value in every other state.

Optional Feature:
- DEBUG_BREAKPOINT_EN:
  - Defined: adds ports bp_pc in 32 (current fetch PC) and bp_addr in 32 (breakpoint address), and command select 6'b111100, which arms the breakpoint.
  - While armed, RUN halts in the cycle where bp_pc==bp_addr; pipe_en is deasserted before that instruction advances.
  - The breakpoint is disarmed on halt.
  - Undefined: none of these ports exist; 6'b111100 is treated as an ordinary probe read.

Test Plan:
- Reset held low 3 cycles, then released -> pipe_en=0, halted=1, tx_start=0, cycle_count=0.
- rx_data=8'h3F (step) sent 3 times -> exactly 3 single-cycle pipe_en pulses, cycle_count=3, no tx_start.
- rx_data=8'hC1 with probe_data=32'hDEADBEEF, tx_busy modelled as 10-cycle busy per byte -> probe_sel=6'h01; tx_data sequence EF, BE, AD, DE; 4 tx_start pulses.
- rx_data=8'h01 (size 00) with the same probe_data -> single byte EF, then IDLE.
- rx_data=8'h38 (run), then rx_data=8'h00 after 50 cycles -> halted drops, pipe_en high ~50 cycles, byte 8'h00 not decoded, cycle_count matches the pipe_en count.
- RUN_LIMIT=20, run command -> auto-halt with cycle_count=20; then 8'hFE -> bytes 14,00,00,00.
